// File: rtl/alu_op_sequencer.sv
// Command sequencer in front of the 16-bit ALU: issues one op per command, captures the result
// into a chaining accumulator and parks in ERROR on ALU error. Optional ALU_SEQ_OPCNT_EN adds op_count.
module alu_op_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_load,
    input  logic [2:0]  cmd_op,
    input  logic [15:0] cmd_y,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic [2:0]  alu_op,
    input  logic [16:0] alu_out,
    input  logic        alu_err,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [16:0] res_data,
    output logic        res_err,
    output logic        err,
    input  logic        err_clr,
    output logic [16:0] acc
`ifdef ALU_SEQ_OPCNT_EN
    ,
    output logic [15:0] op_count
`endif
);

    localparam int unsigned OPND_W = 16;
    localparam int unsigned RES_W  = 17;
    localparam int unsigned OP_W   = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    state_t              state;
    state_t              state_d;
    logic [RES_W-1:0]    acc_d;
    logic [RES_W-1:0]    res_data_d;
    logic                res_err_d;
    logic [OPND_W-1:0]   alu_x_d;
    logic [OPND_W-1:0]   alu_y_d;
    logic [OP_W-1:0]     alu_op_d;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state and next values of every registered output
    always_comb begin
        state_d    = state;
        acc_d      = acc;
        res_data_d = res_data;
        res_err_d  = res_err;
        alu_x_d    = '0;
        alu_y_d    = '0;
        alu_op_d   = '0;
        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_load) begin
                        acc_d      = {1'b0, cmd_y};
                        res_data_d = {1'b0, cmd_y};
                        res_err_d  = 1'b0;
                        state_d    = S_RESP;
                    end else begin
                        alu_x_d  = acc[OPND_W-1:0];
                        alu_y_d  = cmd_y;
                        alu_op_d = cmd_op;
                        state_d  = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // ALU is combinational: its result is valid at the end of this cycle
                if (alu_err) begin
                    res_data_d = '0;
                    res_err_d  = 1'b1;
                end else begin
                    acc_d      = alu_out;
                    res_data_d = alu_out;
                    res_err_d  = 1'b0;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                if (res_ready) begin
                    state_d = res_err ? S_ERROR : S_IDLE;
                end
            end
            S_ERROR: begin
                if (err_clr) begin
                    acc_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath registers; flags are decoded from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_ready <= 1'b0;
            res_valid <= 1'b0;
            err       <= 1'b0;
            res_data  <= '0;
            res_err   <= 1'b0;
            acc       <= '0;
            alu_x     <= '0;
            alu_y     <= '0;
            alu_op    <= '0;
        end else begin
            cmd_ready <= (state_d == S_IDLE);
            res_valid <= (state_d == S_RESP);
            err       <= (state_d == S_ERROR);
            res_data  <= res_data_d;
            res_err   <= res_err_d;
            acc       <= acc_d;
            alu_x     <= alu_x_d;
            alu_y     <= alu_y_d;
            alu_op    <= alu_op_d;
        end
    end

`ifdef ALU_SEQ_OPCNT_EN
    // Counts every completed ISSUE cycle, errored or not; wraps naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            op_count <= '0;
        end else if (state == S_ISSUE) begin
            op_count <= op_count + 16'(1);
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed scenarios plus a randomized run checked
// against an arithmetic reference model, with a behavioural ALU attached to the DUT.
module tb_alu_op_sequencer;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_load;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_y;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [2:0]  alu_op;
    logic [16:0] alu_out;
    logic        alu_err;
    logic        res_valid;
    logic        res_ready;
    logic [16:0] res_data;
    logic        res_err;
    logic        err;
    logic        err_clr;
    logic [16:0] acc;
`ifdef ALU_SEQ_OPCNT_EN
    logic [15:0] op_count;
`endif

    int total;
    int bad;
    logic [16:0] mdl_acc;

    alu_op_sequencer dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
        .cmd_op(cmd_op), .cmd_y(cmd_y),
        .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
        .alu_out(alu_out), .alu_err(alu_err),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
        .err(err), .err_clr(err_clr), .acc(acc)
`ifdef ALU_SEQ_OPCNT_EN
        , .op_count(op_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: returns {err, result[16:0]}
    function automatic logic [17:0] alu_ref(input logic [15:0] x, input logic [15:0] y, input logic [2:0] op);
        logic [16:0] r;
        logic        e;
        e = 1'b0;
        case (op)
            3'd0: begin r = {1'b0, x} + {1'b0, y}; e = r[16]; end
            3'd1: begin r = {1'b0, x} - {1'b0, y}; e = (x < y); end
            3'd2: r = {x, 1'b0};
            3'd3: r = {2'b00, x[15:1]};
            3'd4: r = {1'b0, x & y};
            3'd5: r = {1'b0, x | y};
            3'd6: r = {1'b0, x ^ y};
            default: r = {1'b0, ~x};
        endcase
        return {e, r};
    endfunction

    assign {alu_err, alu_out} = alu_ref(alu_x, alu_y, alu_op);

    // Drives one command from IDLE through its result handshake and reports what was observed
    task automatic run_cmd(input logic ld, input logic [2:0] op, input logic [15:0] y, input int hold,
                           output int lat, output logic [34:0] issue_obs, output logic [17:0] res_obs,
                           output logic [16:0] racc, output logic steady);
        int n;
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        cmd_valid = 1'b1; cmd_load = ld; cmd_op = op; cmd_y = y;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = 3'($urandom); cmd_y = 16'($urandom);
        issue_obs = {alu_x, alu_y, alu_op};
        lat = 1;
        while (!res_valid && lat < 10) begin @(negedge clk); lat++; end
        if (n >= 20) lat = -1;
        res_obs = {res_err, res_data};
        racc = acc;
        steady = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!res_valid || res_data !== res_obs[16:0] || res_err !== res_obs[17] || cmd_ready !== 1'b0)
                steady = 1'b0;
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({cmd_ready, res_valid, err, res_err} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got %b want 0000", {cmd_ready, res_valid, err, res_err});
        end
        total++;
        if ({acc, res_data, alu_x, alu_y, alu_op} !== 69'd0) begin
            bad++; $display("FAIL reset_data got acc=%h res=%h x=%h y=%h op=%h want 0", acc, res_data, alu_x, alu_y, alu_op);
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
        mdl_acc = '0;
    endtask

    task automatic test_chain;
        int lat; logic [34:0] io; logic [17:0] ro; logic [16:0] ra; logic st;
        run_cmd(1'b1, 3'd0, 16'h0008, 0, lat, io, ro, ra, st);
        total++;
        if (lat !== 1 || ro !== {1'b0, 17'h00008}) begin
            bad++; $display("FAIL chain_load got lat=%0d res=%h want lat=1 res=00008", lat, ro);
        end
        run_cmd(1'b0, 3'd0, 16'h0003, 0, lat, io, ro, ra, st);
        total++;
        if (lat !== 2 || io !== {16'h0008, 16'h0003, 3'd0}) begin
            bad++; $display("FAIL chain_add_issue got lat=%0d issue=%h want lat=2 x=0008 y=0003 op=0", lat, io);
        end
        total++;
        if (ro !== {1'b0, 17'h0000B} || ra !== 17'h0000B) begin
            bad++; $display("FAIL chain_add got res=%h acc=%h want res=0000B acc=0000B", ro, ra);
        end
        run_cmd(1'b0, 3'd1, 16'h0001, 0, lat, io, ro, ra, st);
        total++;
        if (ro !== {1'b0, 17'h0000A}) begin bad++; $display("FAIL chain_sub got %h want 0000A", ro); end
        mdl_acc = 17'h0000A;
    endtask

    task automatic test_overflow;
        int lat; logic [34:0] io; logic [17:0] ro; logic [16:0] ra; logic st; logic seen;
        run_cmd(1'b1, 3'd0, 16'h0001, 0, lat, io, ro, ra, st);
        run_cmd(1'b0, 3'd0, 16'hFFFF, 0, lat, io, ro, ra, st);
        total++;
        if (ro !== {1'b1, 17'h00000} || ra !== 17'h00001) begin
            bad++; $display("FAIL ovf_result got res=%h acc=%h want res=1_00000 acc=00001", ro, ra);
        end
        total++;
        if (err !== 1'b1 || cmd_ready !== 1'b0) begin
            bad++; $display("FAIL ovf_error_state got err=%b ready=%b want err=1 ready=0", err, cmd_ready);
        end
        // Commands offered in ERROR must be refused
        seen = 1'b0;
        cmd_valid = 1'b1; cmd_load = 1'b1; cmd_y = 16'h1234;
        repeat (3) begin @(negedge clk); if (res_valid || cmd_ready || !err) seen = 1'b1; end
        cmd_valid = 1'b0; cmd_load = 1'b0;
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL error_refuses got activity=%b want 0", seen); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        total++;
        if (acc !== 17'd0 || cmd_ready !== 1'b1 || err !== 1'b0) begin
            bad++; $display("FAIL err_clr got acc=%h ready=%b err=%b want 0/1/0", acc, cmd_ready, err);
        end
        // err_clr outside ERROR is ignored
        run_cmd(1'b1, 3'd0, 16'h0007, 0, lat, io, ro, ra, st);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        total++;
        if (acc !== 17'h00007 || cmd_ready !== 1'b1) begin
            bad++; $display("FAIL clr_in_idle got acc=%h ready=%b want 00007/1", acc, cmd_ready);
        end
        mdl_acc = 17'h00007;
    endtask

    task automatic test_shift_logic;
        int lat; logic [34:0] io; logic [17:0] ro; logic [16:0] ra; logic st;
        run_cmd(1'b1, 3'd0, 16'h4000, 0, lat, io, ro, ra, st);
        run_cmd(1'b0, 3'd2, 16'h0000, 0, lat, io, ro, ra, st);
        total++;
        if (ro !== {1'b0, 17'h08000}) begin bad++; $display("FAIL shl got %h want 08000", ro); end
        run_cmd(1'b0, 3'd7, 16'h0000, 0, lat, io, ro, ra, st);
        total++;
        if (ro !== {1'b0, 17'h07FFF} || ra !== 17'h07FFF) begin
            bad++; $display("FAIL not got res=%h acc=%h want 07FFF", ro, ra);
        end
        mdl_acc = 17'h07FFF;
    endtask

    task automatic test_back_pressure;
        int lat; logic [34:0] io; logic [17:0] ro; logic [16:0] ra; logic st;
        run_cmd(1'b0, 3'd6, 16'h00FF, 3, lat, io, ro, ra, st);
        total++;
        if (st !== 1'b1 || ro !== {1'b0, 17'h07F00}) begin
            bad++; $display("FAIL backpressure got stable=%b res=%h want 1/07F00", st, ro);
        end
        total++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release got valid=%b ready=%b want 0/1", res_valid, cmd_ready);
        end
        mdl_acc = 17'h07F00;
    endtask

    task automatic test_reset_in_issue;
        logic seen;
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 3'd0; cmd_y = 16'h0003;
        @(negedge clk);
        cmd_valid = 1'b0;
        total++;
        if (alu_x !== 16'h7F00 || alu_y !== 16'h0003) begin
            bad++; $display("FAIL issue_operands got x=%h y=%h want 7F00/0003", alu_x, alu_y);
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({cmd_ready, res_valid, err, res_err, acc, res_data, alu_x, alu_y, alu_op} !== 73'd0) begin
            bad++; $display("FAIL reset_issue got ready=%b valid=%b acc=%h res=%h x=%h want all 0",
                            cmd_ready, res_valid, acc, res_data, alu_x);
        end
        reset = 1'b0;
        seen = 1'b0;
        repeat (6) begin @(negedge clk); if (res_valid !== 1'b0) seen = 1'b1; end
        total++;
        if (seen !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++; $display("FAIL reset_discard got stray_valid=%b ready=%b want 0/1", seen, cmd_ready);
        end
        mdl_acc = '0;
    endtask

    task automatic test_random;
        int lat, elat, hold; logic [34:0] io, eio; logic [17:0] ro, eres, r; logic [16:0] ra; logic st;
        logic ld; logic [2:0] op; logic [15:0] y;
        for (int k = 0; k < 60; k++) begin
            ld = ($urandom_range(0, 3) == 0);
            op = 3'($urandom);
            y = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            hold = $urandom_range(0, 2);
            if (ld) begin
                elat = 1; eio = '0; eres = {1'b0, 1'b0, y}; mdl_acc = {1'b0, y};
            end else begin
                elat = 2; eio = {mdl_acc[15:0], y, op};
                r = alu_ref(mdl_acc[15:0], y, op);
                if (r[17]) eres = {1'b1, 17'd0};
                else begin eres = r; mdl_acc = r[16:0]; end
            end
            run_cmd(ld, op, y, hold, lat, io, ro, ra, st);
            total++;
            if (lat !== elat || io !== eio || ro !== eres || ra !== mdl_acc || st !== 1'b1) begin
                bad++; $display("FAIL rand_%0d got lat=%0d io=%h res=%h acc=%h st=%b want lat=%0d io=%h res=%h acc=%h st=1",
                                k, lat, io, ro, ra, st, elat, eio, eres, mdl_acc);
            end
            if (eres[17]) begin
                total++;
                if (err !== 1'b1 || cmd_ready !== 1'b0) begin
                    bad++; $display("FAIL rand_err_%0d got err=%b ready=%b want 1/0", k, err, cmd_ready);
                end
                err_clr = 1'b1;
                @(negedge clk);
                err_clr = 1'b0;
                mdl_acc = '0;
            end
            total++;
            if (err !== 1'b0 || cmd_ready !== 1'b1 || acc !== mdl_acc) begin
                bad++; $display("FAIL rand_idle_%0d got err=%b ready=%b acc=%h want 0/1/%h", k, err, cmd_ready, acc, mdl_acc);
            end
        end
    endtask

`ifdef ALU_SEQ_OPCNT_EN
    task automatic test_counter;
        int lat; logic [34:0] io; logic [17:0] ro; logic [16:0] ra; logic st;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (op_count !== 16'd0) begin bad++; $display("FAIL cnt_reset got %0d want 0", op_count); end
        run_cmd(1'b1, 3'd0, 16'h0001, 0, lat, io, ro, ra, st);
        run_cmd(1'b0, 3'd0, 16'h0001, 0, lat, io, ro, ra, st);
        run_cmd(1'b0, 3'd2, 16'h0000, 0, lat, io, ro, ra, st);
        run_cmd(1'b0, 3'd1, 16'hFFFF, 0, lat, io, ro, ra, st);
        total++;
        if (op_count !== 16'd3 || err !== 1'b1) begin
            bad++; $display("FAIL cnt_ops got cnt=%0d err=%b want 3/1", op_count, err);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        total++;
        if (op_count !== 16'd3) begin bad++; $display("FAIL cnt_after_clr got %0d want 3", op_count); end
        mdl_acc = '0;
    endtask
`endif

    initial begin
        total = 0; bad = 0; mdl_acc = '0;
        reset = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = '0; cmd_y = '0;
        res_ready = 1'b0; err_clr = 1'b0;
        test_reset();
        test_chain();
        test_overflow();
        test_shift_logic();
        test_back_pressure();
        test_reset_in_issue();
        test_random();
`ifdef ALU_SEQ_OPCNT_EN
        test_counter();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
